multicycle_control_fsm: RTL and testbench

Multi-cycle RV32I control unit. It replaces the single-cycle decoder with a Moore-style state machine that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port. It adds full branch-condition support (beq/bne/blt/bge/bltu/bgeu), jal/jalr/lui/auipc, memory wait-state handshaking and illegal-opcode trapping. It sits between the instruction register (IR) and the datapath muxes and enables.

---
 rtl/multicycle_control_fsm_pkg.sv | 70 +++++++
 rtl/multicycle_control_fsm_if.sv | 40 ++++
 rtl/multicycle_control_fsm_alu_ctrl_decoder.sv | 32 +++
 rtl/multicycle_control_fsm.sv | 156 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath mux selects and small decode helpers.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALR_PC, LUI, AUIPC, TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
    ALU_SRL  = 4'b1000, ALU_SRA  = 4'b1001
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10, SRCA_ZERO = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
  } src_b_t;

  // How the ALU decoder should interpret funct3/funct7 in the current state
  typedef enum logic [1:0] {
    MODE_ADD, MODE_SUB, MODE_RTYPE, MODE_ITYPE
  } alu_mode_t;

  function automatic imm_src_t imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_JAL:          return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:         return IMM_I;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt, input logic ltu);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control FSM (master) and the datapath (slave): IR/flag
// inputs, mux selects, enables, trap flag and performance counters.
interface multicycle_control_fsm_if #(
  parameter int INSTR_WIDTH    = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 32
);
  logic [INSTR_WIDTH-1:0]    instr_i;
  logic                      mem_ready_i;
  logic                      zero_i;
  logic                      lt_i;
  logic                      ltu_i;
  logic                      PCWrite_o;
  logic                      AdrSrc_o;
  logic                      MemWrite_o;
  logic                      IRWrite_o;
  logic [1:0]                ResultSrc_o;
  logic [1:0]                ALUSrcA_o;
  logic [1:0]                ALUSrcB_o;
  logic [ALU_CTRL_WIDTH-1:0] ALUControl_o;
  logic [2:0]                ImmSrc_o;
  logic                      RegWrite_o;
  logic                      illegal_o;
  logic [CNT_WIDTH-1:0]      cycle_cnt_o;
  logic [CNT_WIDTH-1:0]      instret_o;

  modport master (
    input  instr_i, mem_ready_i, zero_i, lt_i, ltu_i,
    output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
           ALUSrcB_o, ALUControl_o, ImmSrc_o, RegWrite_o, illegal_o,
           cycle_cnt_o, instret_o
  );

  modport slave (
    output instr_i, mem_ready_i, zero_i, lt_i, ltu_i,
    input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
           ALUSrcB_o, ALUControl_o, ImmSrc_o, RegWrite_o, illegal_o,
           cycle_cnt_o, instret_o
  );
endinterface

// File: rtl/multicycle_control_fsm_alu_ctrl_decoder.sv
// Combinational ALU control decode from funct3/funct7[5] and the FSM's ALU mode.
module alu_ctrl_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_mode_t  mode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_ctrl_t  alu_ctrl
);

  // funct7[5] means SUB only for R-type; for shifts it selects SRA in both forms
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (mode)
      MODE_SUB: alu_ctrl = ALU_SUB;
      MODE_RTYPE, MODE_ITYPE: begin
        case (funct3)
          3'b000:  alu_ctrl = (mode == MODE_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore-style multi-cycle RV32I control FSM. Optional performance counters are
// built only when PERF_CNT_EN is defined.
module multicycle_control_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input logic                       clk_i,
  input logic                       rst_i,
  multicycle_control_fsm_if.master  bus
);

  state_t      state, next_state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  result_src_t result_src;
  src_a_t      src_a;
  src_b_t      src_b;
  alu_mode_t   alu_mode;
  alu_ctrl_t   alu_ctrl;

  assign opcode       = bus.instr_i[6:0];
  assign funct3       = bus.instr_i[14:12];
  assign funct7b5     = bus.instr_i[30];
  assign unused_instr = ^{bus.instr_i[31], bus.instr_i[29:15], bus.instr_i[11:7]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (bus.mem_ready_i) next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = (funct3 == 3'b000) ? JALR : TRAP;
          OP_LUI:            next_state = LUI;
          OP_AUIPC:          next_state = AUIPC;
          default:           next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready_i) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (bus.mem_ready_i) next_state = FETCH;
      EXECR, EXECI, JAL, JALR_PC, LUI, AUIPC: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BRANCH:   next_state = (funct3 inside {3'b010, 3'b011}) ? TRAP : FETCH;
      JALR:     next_state = JALR_PC;
      default:  next_state = TRAP;
    endcase
  end

  // Reset overrides every state so no enable can leak while rst_i is high
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    alu_mode   = MODE_ADD;
    case (state)
      FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready_i;
        pc_write   = bus.mem_ready_i;
      end
      DECODE:   begin src_a = SRCA_OLDPC; src_b = SRCB_IMM; end
      MEMADR:   begin src_a = SRCA_RD1;   src_b = SRCB_IMM; end
      MEMREAD:  adr_src = 1'b1;
      MEMWB:    begin result_src = RES_RDATA; reg_write = 1'b1; end
      MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      EXECR:    begin src_a = SRCA_RD1; src_b = SRCB_RD2; alu_mode = MODE_RTYPE; end
      EXECI:    begin src_a = SRCA_RD1; src_b = SRCB_IMM; alu_mode = MODE_ITYPE; end
      ALUWB:    reg_write = 1'b1;
      BRANCH: begin
        src_a    = SRCA_RD1;
        src_b    = SRCB_RD2;
        alu_mode = MODE_SUB;
        pc_write = branch_taken(funct3, bus.zero_i, bus.lt_i, bus.ltu_i);
      end
      JAL, JALR_PC: begin src_a = SRCA_OLDPC; src_b = SRCB_FOUR; pc_write = 1'b1; end
      JALR:     begin src_a = SRCA_RD1;   src_b = SRCB_IMM; end
      LUI:      begin src_a = SRCA_ZERO;  src_b = SRCB_IMM; end
      AUIPC:    begin src_a = SRCA_OLDPC; src_b = SRCB_IMM; end
      default:  ;
    endcase
    if (rst_i) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      src_a      = SRCA_PC;
      src_b      = SRCB_RD2;
      alu_mode   = MODE_ADD;
    end
  end

  alu_ctrl_decoder u_alu_ctrl_decoder (
    .mode     (alu_mode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (alu_ctrl)
  );

  assign bus.PCWrite_o    = pc_write;
  assign bus.AdrSrc_o     = adr_src;
  assign bus.MemWrite_o   = mem_write;
  assign bus.IRWrite_o    = ir_write;
  assign bus.RegWrite_o   = reg_write;
  assign bus.ResultSrc_o  = result_src;
  assign bus.ALUSrcA_o    = src_a;
  assign bus.ALUSrcB_o    = src_b;
  assign bus.ALUControl_o = alu_ctrl;
  assign bus.ImmSrc_o     = rst_i ? IMM_I : imm_src_of(opcode);
  assign bus.illegal_o    = (state == TRAP);

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // An instruction retires whenever the FSM comes back to FETCH
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (state != TRAP) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (next_state == FETCH && state != FETCH) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

  assign bus.cycle_cnt_o = cycle_cnt;
  assign bus.instret_o   = instret_cnt;
`else
  assign bus.cycle_cnt_o = {CNT_WIDTH{1'b0}};
  assign bus.instret_o   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; counter checks follow PERF_CNT_EN.
module tb_multicycle_control_fsm;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_bad    = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Control word: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, SrcA, SrcB, ALUControl, RegWrite, illegal}
  localparam logic [15:0] W_RESET      = 16'h0000;
  localparam logic [15:0] W_FETCH      = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_FETCH_WAIT = {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_DECODE     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_EXECR_ADD  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_EXECR_SUB  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'h1, 1'b0, 1'b0};
  localparam logic [15:0] W_EXECI_SRA  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h9, 1'b0, 1'b0};
  localparam logic [15:0] W_ALUWB      = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b1, 1'b0};
  localparam logic [15:0] W_MEMADR     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_MEMREAD    = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_MEMWB      = {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 4'h0, 1'b1, 1'b0};
  localparam logic [15:0] W_MEMWRITE   = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_BR_TAKEN   = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'h1, 1'b0, 1'b0};
  localparam logic [15:0] W_BR_NOT     = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'h1, 1'b0, 1'b0};
  localparam logic [15:0] W_JAL        = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_LUI        = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 4'h0, 1'b0, 1'b0};
  localparam logic [15:0] W_TRAP       = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 1'b1};

  function automatic logic [15:0] ctl_word();
    return {bus.PCWrite_o, bus.AdrSrc_o, bus.MemWrite_o, bus.IRWrite_o, bus.ResultSrc_o,
            bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUControl_o, bus.RegWrite_o, bus.illegal_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.zero_i = 1'b1;
    tick();
    n_checks++;
    if (ctl_word() !== W_RESET) begin
      n_bad++; $display("[TB] FAIL reset_outputs got=%h exp=%h", ctl_word(), W_RESET);
    end
    n_checks++;
    if (bus.cycle_cnt_o !== 32'd0 || bus.instret_o !== 32'd0) begin
      n_bad++; $display("[TB] FAIL reset_counters got=%0d/%0d exp=0/0", bus.cycle_cnt_o, bus.instret_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.zero_i = 1'b0;
    #1;
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL reset_release_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
  endtask

  task automatic test_add();
    bus.instr_i = 32'h002081B3;
    #1;
    tick();
    n_checks++;
    if (ctl_word() !== W_DECODE) begin
      n_bad++; $display("[TB] FAIL add_decode got=%h exp=%h", ctl_word(), W_DECODE);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_EXECR_ADD) begin
      n_bad++; $display("[TB] FAIL add_execr got=%h exp=%h", ctl_word(), W_EXECR_ADD);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_ALUWB) begin
      n_bad++; $display("[TB] FAIL add_aluwb got=%h exp=%h", ctl_word(), W_ALUWB);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL add_back_to_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
  endtask

  task automatic test_sub_srai();
    bus.instr_i = 32'h402081B3;
    tick();
    tick();
    n_checks++;
    if (ctl_word() !== W_EXECR_SUB) begin
      n_bad++; $display("[TB] FAIL sub_execr got=%h exp=%h", ctl_word(), W_EXECR_SUB);
    end
    tick();
    tick();
    bus.instr_i = 32'h4020D193;
    tick();
    tick();
    n_checks++;
    if (ctl_word() !== W_EXECI_SRA) begin
      n_bad++; $display("[TB] FAIL srai_execi got=%h exp=%h", ctl_word(), W_EXECI_SRA);
    end
    n_checks++;
    if (bus.ImmSrc_o !== 3'b000) begin
      n_bad++; $display("[TB] FAIL srai_immsrc got=%b exp=000", bus.ImmSrc_o);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_ALUWB) begin
      n_bad++; $display("[TB] FAIL srai_aluwb got=%h exp=%h", ctl_word(), W_ALUWB);
    end
    tick();
  endtask

  task automatic test_load_wait();
    bus.instr_i = 32'h0040A283;
    bus.mem_ready_i = 1'b0;
    #1;
    n_checks++;
    if (ctl_word() !== W_FETCH_WAIT) begin
      n_bad++; $display("[TB] FAIL fetch_wait got=%h exp=%h", ctl_word(), W_FETCH_WAIT);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_FETCH_WAIT) begin
      n_bad++; $display("[TB] FAIL fetch_hold got=%h exp=%h", ctl_word(), W_FETCH_WAIT);
    end
    bus.mem_ready_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ctl_word() !== W_MEMADR) begin
      n_bad++; $display("[TB] FAIL lw_memadr got=%h exp=%h", ctl_word(), W_MEMADR);
    end
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ctl_word() !== W_MEMREAD) begin
        n_bad++; $display("[TB] FAIL lw_memread_wait%0d got=%h exp=%h", i, ctl_word(), W_MEMREAD);
      end
    end
    tick();
    bus.mem_ready_i = 1'b1;
    #1;
    n_checks++;
    if (ctl_word() !== W_MEMREAD) begin
      n_bad++; $display("[TB] FAIL lw_memread_last got=%h exp=%h", ctl_word(), W_MEMREAD);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_MEMWB) begin
      n_bad++; $display("[TB] FAIL lw_memwb got=%h exp=%h", ctl_word(), W_MEMWB);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL lw_back_to_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
  endtask

  task automatic test_store_wait();
    bus.instr_i = 32'h0050A423;
    tick();
    n_checks++;
    if (bus.ImmSrc_o !== 3'b001) begin
      n_bad++; $display("[TB] FAIL sw_immsrc got=%b exp=001", bus.ImmSrc_o);
    end
    tick();
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        bus.mem_ready_i = 1'b1;
        #1;
      end
      n_checks++;
      if (ctl_word() !== W_MEMWRITE) begin
        n_bad++; $display("[TB] FAIL sw_memwrite%0d got=%h exp=%h", i, ctl_word(), W_MEMWRITE);
      end
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL sw_back_to_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
  endtask

  task automatic test_branch();
    bus.instr_i = 32'h00208463;
    bus.zero_i = 1'b1;
    tick();
    n_checks++;
    if (bus.ImmSrc_o !== 3'b010) begin
      n_bad++; $display("[TB] FAIL beq_immsrc got=%b exp=010", bus.ImmSrc_o);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_BR_TAKEN) begin
      n_bad++; $display("[TB] FAIL beq_taken got=%h exp=%h", ctl_word(), W_BR_TAKEN);
    end
    bus.zero_i = 1'b0;
    #1;
    n_checks++;
    if (ctl_word() !== W_BR_NOT) begin
      n_bad++; $display("[TB] FAIL beq_not_taken got=%h exp=%h", ctl_word(), W_BR_NOT);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL beq_back_to_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
    bus.instr_i = 32'h0020D463;
    bus.lt_i = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ctl_word() !== W_BR_TAKEN) begin
      n_bad++; $display("[TB] FAIL bge_taken got=%h exp=%h", ctl_word(), W_BR_TAKEN);
    end
    bus.lt_i = 1'b1;
    #1;
    n_checks++;
    if (ctl_word() !== W_BR_NOT) begin
      n_bad++; $display("[TB] FAIL bge_not_taken got=%h exp=%h", ctl_word(), W_BR_NOT);
    end
    tick();
    bus.instr_i = 32'h0020E463;
    bus.ltu_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (ctl_word() !== W_BR_TAKEN) begin
      n_bad++; $display("[TB] FAIL bltu_taken got=%h exp=%h", ctl_word(), W_BR_TAKEN);
    end
    bus.ltu_i = 1'b0;
    #1;
    n_checks++;
    if (ctl_word() !== W_BR_NOT) begin
      n_bad++; $display("[TB] FAIL bltu_not_taken got=%h exp=%h", ctl_word(), W_BR_NOT);
    end
    tick();
  endtask

  task automatic test_jal_lui();
    bus.instr_i = 32'h008000EF;
    tick();
    n_checks++;
    if (bus.ImmSrc_o !== 3'b011) begin
      n_bad++; $display("[TB] FAIL jal_immsrc got=%b exp=011", bus.ImmSrc_o);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_JAL) begin
      n_bad++; $display("[TB] FAIL jal_state got=%h exp=%h", ctl_word(), W_JAL);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_ALUWB) begin
      n_bad++; $display("[TB] FAIL jal_aluwb got=%h exp=%h", ctl_word(), W_ALUWB);
    end
    tick();
    bus.instr_i = 32'h123450B7;
    tick();
    n_checks++;
    if (bus.ImmSrc_o !== 3'b100) begin
      n_bad++; $display("[TB] FAIL lui_immsrc got=%b exp=100", bus.ImmSrc_o);
    end
    tick();
    n_checks++;
    if (ctl_word() !== W_LUI) begin
      n_bad++; $display("[TB] FAIL lui_state got=%h exp=%h", ctl_word(), W_LUI);
    end
    tick();
    tick();
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL lui_back_to_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.instr_i = 32'h0050A423;
    tick();
    tick();
    bus.mem_ready_i = 1'b0;
    tick();
    n_checks++;
    if (ctl_word() !== W_MEMWRITE) begin
      n_bad++; $display("[TB] FAIL midrst_memwrite got=%h exp=%h", ctl_word(), W_MEMWRITE);
    end
    #1;
    rst_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    n_checks++;
    if (ctl_word() !== W_RESET) begin
      n_bad++; $display("[TB] FAIL midrst_outputs got=%h exp=%h", ctl_word(), W_RESET);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (ctl_word() !== W_FETCH) begin
      n_bad++; $display("[TB] FAIL midrst_fetch got=%h exp=%h", ctl_word(), W_FETCH);
    end
  endtask

  task automatic test_trap();
    bus.instr_i = 32'hFFFFFFFF;
    tick();
    tick();
    bus.zero_i = 1'b1;
    bus.lt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (ctl_word() !== W_TRAP) begin
        n_bad++; $display("[TB] FAIL trap_cycle%0d got=%h exp=%h", i, ctl_word(), W_TRAP);
      end
      tick();
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (ctl_word() !== W_RESET) begin
      n_bad++; $display("[TB] FAIL trap_exit_reset got=%h exp=%h", ctl_word(), W_RESET);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_counters();
    logic [31:0] exp_cycle_a, exp_ret_a, exp_cycle_b, exp_ret_b;
`ifdef PERF_CNT_EN
    exp_cycle_a = 32'd4;
    exp_ret_a   = 32'd1;
    exp_cycle_b = 32'd6;
    exp_ret_b   = 32'd1;
`else
    exp_cycle_a = 32'd0;
    exp_ret_a   = 32'd0;
    exp_cycle_b = 32'd0;
    exp_ret_b   = 32'd0;
`endif
    rst_i = 1'b1;
    bus.instr_i = 32'h002081B3;
    bus.mem_ready_i = 1'b1;
    tick();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (bus.cycle_cnt_o !== exp_cycle_a || bus.instret_o !== exp_ret_a) begin
      n_bad++;
      $display("[TB] FAIL cnt_after_add got=%0d/%0d exp=%0d/%0d", bus.cycle_cnt_o, bus.instret_o, exp_cycle_a, exp_ret_a);
    end
    bus.instr_i = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bus.cycle_cnt_o !== exp_cycle_b || bus.instret_o !== exp_ret_b) begin
      n_bad++;
      $display("[TB] FAIL cnt_frozen_in_trap got=%0d/%0d exp=%0d/%0d", bus.cycle_cnt_o, bus.instret_o, exp_cycle_b, exp_ret_b);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.instr_i = 32'h0;
    bus.mem_ready_i = 1'b0;
    bus.zero_i = 1'b0;
    bus.lt_i = 1'b0;
    bus.ltu_i = 1'b0;
    test_reset();
    test_add();
    test_sub_srai();
    test_load_wait();
    test_store_wait();
    test_branch();
    test_jal_lui();
    test_reset_mid_write();
    test_trap();
    test_counters();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
